life_gen_scheduler: RTL and testbench

Sequences one Game of Life generation: scans every cell coordinate of the grid to the cell-update engine with a valid/ready handshake, then pulses a buffer swap. Generations are triggered by an internal run-rate prescaler, a single-step pulse, or a clear request that zeroes the grid. It sits between the user controls and the update datapath. It owns the x/y scan counters and the generation-rate counter.

---
 rtl/life_gen_scheduler_if.sv | 14 +
 rtl/life_gen_scheduler.sv | 113 +++++++++++
 tb/tb_life_gen_scheduler.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/life_gen_scheduler_if.sv
// life_gen_scheduler_if: cell scan handshake bus between the scheduler and the cell-update engine
interface life_gen_scheduler_if #(
  parameter int X_WIDTH = 6,
  parameter int Y_WIDTH = 6
);
  logic               cell_valid;
  logic               cell_ready;
  logic [X_WIDTH-1:0] cell_x;
  logic [Y_WIDTH-1:0] cell_y;
  logic               cell_clear;
  logic               swap;
  modport master (output cell_valid, cell_x, cell_y, cell_clear, swap, input cell_ready);
  modport slave  (input cell_valid, cell_x, cell_y, cell_clear, swap, output cell_ready);
endinterface

// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler: sequences Game of Life generations and clear passes over the grid (optional SCHED_GEN_LIMIT_EN adds a generation limit)
module life_gen_scheduler #(
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 48,
  parameter int X_WIDTH   = 6,
  parameter int Y_WIDTH   = 6,
  parameter int GEN_DIV   = 1000000,
  parameter int DIV_WIDTH = 20,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic                 clear_req,
  life_gen_scheduler_if.master cell_if,
`ifdef SCHED_GEN_LIMIT_EN
  input  logic [GEN_WIDTH-1:0] gen_limit,
  output logic                 limit_hit,
`endif
  output logic                 busy,
  output logic [GEN_WIDTH-1:0] generation
);
  typedef enum logic [1:0] {IDLE, SCAN, CLEAR, COMMIT} state_t;
  localparam logic [X_WIDTH-1:0]   X_LAST   = X_WIDTH'(GRID_W - 1);
  localparam logic [Y_WIDTH-1:0]   Y_LAST   = Y_WIDTH'(GRID_H - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(GEN_DIV - 1);
  state_t               state_q, state_d;
  logic [X_WIDTH-1:0]   x_q, x_d;
  logic [Y_WIDTH-1:0]   y_q, y_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [GEN_WIDTH-1:0] gen_q, gen_d;
  logic                 gen_pend_q, gen_pend_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 hold, term, tick, gen_req, clr_req, valid, xfer, x_end, last;
`ifdef SCHED_GEN_LIMIT_EN
  assign limit_hit = gen_limit != '0 && gen_q == gen_limit;
  assign hold      = limit_hit;
`else
  assign hold      = 1'b0;
`endif
  assign term    = run && div_q == DIV_LAST;
  assign tick    = term && !hold;
  assign div_d   = run && !term ? div_q + 1'b1 : '0;
  assign gen_req = gen_pend_q | tick | step;
  assign clr_req = clr_pend_q | clear_req;
  assign valid   = state_q == SCAN || state_q == CLEAR;
  assign xfer    = valid && cell_if.cell_ready;
  assign x_end   = x_q == X_LAST;
  assign last    = x_end && y_q == Y_LAST;
  assign cell_if.cell_valid = valid;
  assign cell_if.cell_x     = x_q;
  assign cell_if.cell_y     = y_q;
  assign cell_if.cell_clear = state_q == CLEAR;
  assign cell_if.swap       = state_q == COMMIT;
  assign busy               = state_q != IDLE;
  assign generation         = gen_q;
  // next state: request capture, scan counter advance and generation bookkeeping
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    gen_d      = gen_q;
    gen_pend_d = gen_req;
    clr_pend_d = clr_req;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
        end else if (gen_req) begin
          state_d    = SCAN;
          gen_pend_d = 1'b0;
        end
      end
      SCAN, CLEAR: begin
        if (xfer) begin
          x_d = x_end ? '0 : x_q + 1'b1;
          y_d = last ? '0 : x_end ? y_q + 1'b1 : y_q;
          if (last) begin
            state_d = state_q == SCAN ? COMMIT : IDLE;
            gen_d   = state_q == SCAN ? gen_q : '0;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        gen_d   = gen_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset that aborts any scan and drops pending requests
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      div_q      <= '0;
      gen_q      <= '0;
      gen_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      div_q      <= div_d;
      gen_q      <= gen_d;
      gen_pend_q <= gen_pend_d;
      clr_pend_q <= clr_pend_d;
    end
  end
endmodule

// File: tb/tb_life_gen_scheduler.sv
// tb_life_gen_scheduler: directed tests against a cell-index model of the generation scheduler
module tb_life_gen_scheduler;
  localparam int W = 4, H = 3, N = W * H, DIV = 20, GW = 16;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0, clear_req = 1'b0;
  logic busy;
  logic [GW-1:0] generation;
  life_gen_scheduler_if #(.X_WIDTH(2), .Y_WIDTH(2)) cif ();
`ifdef SCHED_GEN_LIMIT_EN
  logic [GW-1:0] gen_limit = '0;
  logic limit_hit;
`endif
  life_gen_scheduler #(
    .GRID_W(W), .GRID_H(H), .X_WIDTH(2), .Y_WIDTH(2),
    .GEN_DIV(DIV), .DIV_WIDTH(5), .GEN_WIDTH(GW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .clear_req(clear_req),
    .cell_if(cif),
`ifdef SCHED_GEN_LIMIT_EN
    .gen_limit(gen_limit), .limit_hit(limit_hit),
`endif
    .busy(busy), .generation(generation)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0, n_swap = 0, n_xfer = 0;
  int seen[N];
  bit chk_en = 1'b0;
  int m_mode = 0, m_idx = 0, m_pre = 0, m_gen = 0;
  bit m_gp = 1'b0, m_cp = 1'b0;
  bit tk, lim, greq, creq;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input string name);
    int b = 0;
    while (busy && b < 80) begin
      cyc();
      b++;
    end
    check(name, busy, 0);
  endtask
  // model: modes 0 idle, 1 scan, 2 clear, 3 commit; the scan position is a linear cell index
  always @(posedge clk) begin
`ifdef SCHED_GEN_LIMIT_EN
    lim = gen_limit != 0 && m_gen == int'(gen_limit);
`else
    lim = 1'b0;
`endif
    if (reset) begin
      m_mode = 0; m_idx = 0; m_pre = 0; m_gen = 0; m_gp = 0; m_cp = 0;
    end else begin
      tk    = run && m_pre == DIV - 1;
      m_pre = (run && !tk) ? m_pre + 1 : 0;
      greq  = m_gp || (tk && !lim) || step;
      creq  = m_cp || clear_req;
      m_gp  = greq;
      m_cp  = creq;
      case (m_mode)
        0: if (creq) begin m_mode = 2; m_cp = 0; end
           else if (greq) begin m_mode = 1; m_gp = 0; end
        1, 2: if (cif.cell_ready) begin
          if (m_idx == N - 1) begin
            m_idx = 0;
            if (m_mode == 2) m_gen = 0;
            m_mode = (m_mode == 1) ? 3 : 0;
          end else m_idx++;
        end
        default: begin m_gen = (m_gen + 1) % 65536; m_mode = 0; end
      endcase
    end
  end
  // compare every output with the model each cycle, and tally swaps and delivered cells
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_valid", cif.cell_valid, m_mode == 1 || m_mode == 2);
      if (m_mode == 1 || m_mode == 2) begin
        check("cmp_x", cif.cell_x, m_idx % W);
        check("cmp_y", cif.cell_y, m_idx / W);
        check("cmp_clear", cif.cell_clear, m_mode == 2);
      end
      check("cmp_swap", cif.swap, m_mode == 3);
      check("cmp_busy", busy, m_mode != 0);
      check("cmp_gen", generation, m_gen);
`ifdef SCHED_GEN_LIMIT_EN
      check("cmp_limit", limit_hit, gen_limit != 0 && m_gen == int'(gen_limit));
`endif
      if (cif.swap) n_swap++;
      if (cif.cell_valid && cif.cell_ready) begin
        n_xfer++;
        if (int'(cif.cell_y) * W + int'(cif.cell_x) < N) seen[int'(cif.cell_y) * W + int'(cif.cell_x)]++;
      end
    end
  end
  initial begin
    int xs[N] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int ys[N] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    int s0, x0, b, px, py, pv, pr;
    cif.cell_ready = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_valid", cif.cell_valid, 0);
    check("rst_x", cif.cell_x, 0);
    check("rst_y", cif.cell_y, 0);
    check("rst_swap", cif.swap, 0);
    check("rst_busy", busy, 0);
    check("rst_gen", generation, 0);
    repeat (6) cyc();
    step = 1'b1; cyc(); step = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("t1_valid", cif.cell_valid, 1);
      check("t1_x", cif.cell_x, xs[k]);
      check("t1_y", cif.cell_y, ys[k]);
      cyc();
    end
    check("t1_swap", cif.swap, 1);
    cyc();
    check("t1_busy", busy, 0);
    check("t1_gen", generation, 1);
    s0 = n_swap; x0 = n_xfer;
    foreach (seen[i]) seen[i] = 0;
    cif.cell_ready = 1'b0;
    step = 1'b1; cyc(); step = 1'b0;
    b = 0;
    while (busy && b < 60) begin
      px = cif.cell_x; py = cif.cell_y; pv = cif.cell_valid; pr = cif.cell_ready;
      cyc();
      if (pv && !pr && cif.cell_valid) begin
        check("t2_hold_x", cif.cell_x, px);
        check("t2_hold_y", cif.cell_y, py);
      end
      cif.cell_ready = ~cif.cell_ready;
      b++;
    end
    cif.cell_ready = 1'b1;
    check("t2_done", busy, 0);
    check("t2_xfers", n_xfer - x0, N);
    foreach (seen[i]) check("t2_once", seen[i], 1);
    check("t2_swaps", n_swap - s0, 1);
    check("t2_gen", generation, 2);
    s0 = n_swap;
    run = 1'b1;
    repeat (100) cyc();
    run = 1'b0;
    check("t3_midscan", busy, 1);
    wait_idle("t3_finish");
    repeat (30) begin
      check("t3_stopped", busy, 0);
      cyc();
    end
    check("t3_gen", generation, 7);
    check("t3_swaps", n_swap - s0, 5);
    s0 = n_swap;
    step = 1'b1; cyc(); step = 1'b0; cyc(); cyc();
    step = 1'b1; cyc(); step = 1'b0; cyc();
    step = 1'b1; cyc(); step = 1'b0;
    b = 0;
    while (!cif.swap && b < 30) begin
      cyc();
      b++;
    end
    check("t4_swap_seen", cif.swap, 1);
    cyc();
    check("t4_gap", busy, 0);
    cyc();
    check("t4_restart", cif.cell_valid, 1);
    check("t4_x0", cif.cell_x, 0);
    check("t4_y0", cif.cell_y, 0);
    wait_idle("t4_finish");
    check("t4_gen", generation, 9);
    check("t4_swaps", n_swap - s0, 2);
    clear_req = 1'b1; step = 1'b1; cyc(); clear_req = 1'b0; step = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("t5_clr_valid", cif.cell_valid, 1);
      check("t5_clr_flag", cif.cell_clear, 1);
      cyc();
    end
    check("t5_gap", busy, 0);
    check("t5_gen0", generation, 0);
    cyc();
    for (int k = 0; k < N; k++) begin
      check("t5_scan_valid", cif.cell_valid, 1);
      check("t5_scan_flag", cif.cell_clear, 0);
      cyc();
    end
    check("t5_swap", cif.swap, 1);
    cyc();
    check("t5_gen1", generation, 1);
    step = 1'b1; cyc(); step = 1'b0; cyc();
    step = 1'b1; cyc(); step = 1'b0; cyc(); cyc();
    check("t6_fifth_x", cif.cell_x, 0);
    check("t6_fifth_y", cif.cell_y, 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    check("t6_valid", cif.cell_valid, 0);
    check("t6_x", cif.cell_x, 0);
    check("t6_y", cif.cell_y, 0);
    check("t6_clear", cif.cell_clear, 0);
    check("t6_swap", cif.swap, 0);
    check("t6_busy", busy, 0);
    check("t6_gen", generation, 0);
    s0 = n_swap;
    repeat (30) begin
      check("t6_no_resume", busy, 0);
      cyc();
    end
    check("t6_no_swap", n_swap - s0, 0);
`ifdef SCHED_GEN_LIMIT_EN
    gen_limit = 16'd3;
    run = 1'b1;
    repeat (150) cyc();
    check("lim_gen", generation, 3);
    check("lim_hit", limit_hit, 1);
    check("lim_idle", busy, 0);
    run = 1'b0;
    step = 1'b1; cyc(); step = 1'b0;
    wait_idle("lim_step");
    check("lim_step_gen", generation, 4);
    check("lim_released", limit_hit, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
